serial_pattern_gen: RTL and testbench
=====================================

# serial_pattern_gen

Serial bit-pattern transmitter: loads a programmable pattern of up to MAX_W bits and shifts it out MSB-first, one bit per clock, on a single-bit serial line. It optionally repeats the frame with idle gaps between repeats. It is the transmit end of the serial sequence-detection path. It drives the `d_in` of the Mealy/Moore sequence detectors (e.g. 10101) with deterministic, back-to-back and overlapping patterns.

## Interface
Parameters:
- `MAX_W`, default 16: maximum pattern length in bits.
- `LW`, default `$clog2(MAX_W+1)`: width of `pat_len`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transmission; sampled only in IDLE.
- `pat_in`  in  MAX_W  pattern; bit `pat_len-1` is sent first, bit 0 last.
- `pat_len`  in  LW  pattern length, 1..MAX_W.
- `rpt`  in  8  additional repetitions; total frames = `rpt`+1.
- `gap`  in  4  idle cycles inserted between frames.
- `d_out`  out  1  serial data, registered.
- `d_valid`  out  1  high while `d_out` carries a pattern bit.
- `busy`  out  1  high from the start acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse after the last bit of the last frame.

## Operation
- State machine states: IDLE, SHIFT, GAP, DONE.
- Reset: state=IDLE. `d_out`=0, `d_valid`=0, `busy`=0, `done`=0. Bit counter, repeat counter and gap counter are all 0.
- IDLE, with `start`=1 and `pat_len`≠0:
  - capture `pat_in`, `pat_len`, `rpt` and `gap`;
  - go to SHIFT with the first bit presented.
- `pat_len`=0: `start` is ignored and the block stays in IDLE.
- `pat_len`>MAX_W: the length is clamped to MAX_W.
- SHIFT: emits one bit per cycle with `d_valid`=1. Bit index counts down from `len-1` to 0. After bit 0:
  - repeats remaining and captured `gap`≠0 → go to GAP;
  - repeats remaining and `gap`=0 → reload the index and continue SHIFT with no bubble;
  - no repeats remaining → go to DONE.
- GAP: lasts exactly `gap` cycles with `d_valid`=0, then goes to SHIFT and decrements the repeat counter.
- DONE: lasts one cycle with `done`=1, `busy`=1 and `d_valid`=0, then goes to IDLE.
- `start` outside IDLE, including in the DONE cycle, is ignored; there is no queuing.
- Input changes after capture have no effect on the frame in flight.
- Reset mid-operation: the next edge forces the IDLE/reset values, and the frame is abandoned with no `done` pulse.
- `d_out` when `d_valid`=0 is 0, unless the feature in Configuration is enabled.

## Timing
- `start` sampled high at edge N in IDLE.
  - Bit `len-1` appears on `d_out`, with `d_valid`=1 and `busy`=1, in the cycle after edge N.
  - Frame bits occupy cycles N+1 … N+L, where L is the effective length.
- Total busy cycles = (`rpt`+1)·L + `rpt`·`gap` + 1 (the DONE cycle).
- `done` is high in the cycle immediately after the last valid bit.
- The earliest next `start` is accepted at the edge ending the cycle after DONE, i.e. the first IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_PATTERN_GEN_LFSR_FILL_EN`, when defined:
  - an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is instantiated;
  - it is seeded to 8'hA5 on `reset` and advances every cycle;
  - whenever `d_valid`=0 (IDLE, GAP, DONE), `d_out` = LFSR bit 0. This fills the line with noise to stress detector resynchronisation.
- When not defined: the LFSR is absent and `d_out`=0 whenever `d_valid`=0. Pattern bits and all timing are identical in both builds.

## Test plan
- Reset release, no `start`: all outputs stay 0 for 20 cycles; with the macro defined, `d_out` follows the LFSR sequence from seed A5.
- `pat_in`=5'b10101, `pat_len`=5, `rpt`=0, `gap`=0, pulse `start`:
  - `d_out` = 1,0,1,0,1 in cycles N+1..N+5 with `d_valid`=1;
  - `done` pulses at N+6;
  - `busy` is high N+1..N+6;
  - a chained 10101 detector flags exactly once.
- Same pattern with `rpt`=2, `gap`=0: 15 contiguous valid bits 101011010110101; `done` at N+16.
- Same pattern with `rpt`=1, `gap`=3:
  - valid N+1..N+5;
  - `d_valid`=0 N+6..N+8;
  - valid N+9..N+13;
  - `done` at N+14.
- `pat_len`=0 with `start` → no activity. `start` re-asserted mid-frame and in the DONE cycle → ignored, and the frame bits are unchanged.
- `reset` asserted during the 3rd bit of 10101 → all outputs 0 the next cycle, no `done`. A subsequent `start` runs a full clean frame.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: loads a pattern of up to MAX_W bits and shifts it out MSB-first,
// one bit per clock, optionally repeating the frame with idle gaps in between.
// Optional build macro SERIAL_PATTERN_GEN_LFSR_FILL_EN: drives LFSR noise on d_out whenever
// d_valid is low instead of 0.
module serial_pattern_gen #(
  parameter int unsigned MAX_W = 16,
  parameter int unsigned LW    = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MAX_W-1:0] pat_in,
  input  logic [LW-1:0]    pat_len,
  input  logic [7:0]       rpt,
  input  logic [3:0]       gap,
  output logic             d_out,
  output logic             d_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [LW-1:0] MaxLen = LW'(MAX_W);

  logic [1:0]       state_q, state_d;
  // pat_q holds the captured pattern left-aligned so the first bit is always the MSB
  logic [MAX_W-1:0] pat_q, pat_d;
  logic [MAX_W-1:0] sh_q, sh_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [7:0]       rpt_q, rpt_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LW-1:0]    len_eff;
  logic [MAX_W-1:0] pat_aligned;
  logic             fill;

  // Next-state logic for the frame sequencer
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sh_d      = sh_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rpt_d     = rpt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = bit_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    len_eff     = (pat_len > MaxLen) ? MaxLen : pat_len;
    pat_aligned = pat_in << (MaxLen - len_eff);

    case (state_q)
      StIdle: begin
        if (start && (pat_len != '0)) begin
          state_d = StShift;
          pat_d   = pat_aligned;
          sh_d    = pat_aligned << 1;
          bit_d   = pat_aligned[MAX_W-1];
          len_d   = len_eff;
          idx_d   = len_eff - 1'b1;
          rpt_d   = rpt;
          gap_d   = gap;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StShift: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
          bit_d = sh_q[MAX_W-1];
          sh_d  = sh_q << 1;
        end else if (rpt_q != 8'd0) begin
          if (gap_q != 4'd0) begin
            state_d   = StGap;
            gap_cnt_d = gap_q;
            valid_d   = 1'b0;
            bit_d     = 1'b0;
          end else begin
            // Back-to-back repeat: reload without a bubble
            rpt_d = rpt_q - 8'd1;
            idx_d = len_q - 1'b1;
            bit_d = pat_q[MAX_W-1];
            sh_d  = pat_q << 1;
          end
        end else begin
          state_d = StDone;
          valid_d = 1'b0;
          bit_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd1) begin
          state_d = StShift;
          rpt_d   = rpt_q - 8'd1;
          idx_d   = len_q - 1'b1;
          bit_d   = pat_q[MAX_W-1];
          sh_d    = pat_q << 1;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      sh_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rpt_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      sh_q      <= sh_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rpt_q     <= rpt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SERIAL_PATTERN_GEN_LFSR_FILL_EN
  logic [7:0] lfsr_q;

  // Free-running noise source, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign fill = lfsr_q[0];
`else
  assign fill = 1'b0;
`endif

  assign d_out   = valid_q ? bit_q : fill;
  assign d_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: per-cycle output expectations are built from the
// frame rules (bits, repeats, gaps, done cycle) and compared at the falling clock edge.
module tb_serial_pattern_gen;

  localparam int MAX_W = 16;
  localparam int LW    = $clog2(MAX_W + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [MAX_W-1:0] pat_in = '0;
  logic [LW-1:0]    pat_len = '0;
  logic [7:0]       rpt = '0;
  logic [3:0]       gap = '0;
  logic             d_out, d_valid, busy, done;

  int total = 0;
  int bad = 0;
  // Each entry: {valid, data bit, busy, done}
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  serial_pattern_gen #(.MAX_W(MAX_W), .LW(LW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .pat_in (pat_in),
    .pat_len(pat_len),
    .rpt    (rpt),
    .gap    (gap),
    .d_out  (d_out),
    .d_valid(d_valid),
    .busy   (busy),
    .done   (done)
  );

`ifdef SERIAL_PATTERN_GEN_LFSR_FILL_EN
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
  function automatic logic fill_bit();
    return m_lfsr[0];
  endfunction
`else
  function automatic logic fill_bit();
    return 1'b0;
  endfunction
`endif

  // Reference: whole transaction as a list of cycles, starting the cycle after the start edge
  function automatic void build_expect(logic [MAX_W-1:0] pat, int len, int r, int g);
    int l;
    exp_q.delete();
    if (len == 0) begin
      repeat (3) exp_q.push_back(4'b0000);
      return;
    end
    l = (len > MAX_W) ? MAX_W : len;
    for (int f = 0; f <= r; f++) begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0});
      if (f < r) repeat (g) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endfunction

  function automatic logic [3:0] full_exp(logic [3:0] e);
    return {e[3], e[3] ? e[2] : fill_bit(), e[1], e[0]};
  endfunction

  task automatic drive_start(logic [MAX_W-1:0] p, int len, int r, int g);
    pat_in  = p;
    pat_len = LW'(len);
    rpt     = 8'(r);
    gap     = 4'(g);
    start   = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] act, want;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      act  = {d_valid, d_out, busy, done};
      want = full_exp(4'b0000);
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, act, want);
      end
    end
  endtask

  // 10101 with (rpt,gap) = (0,0), (2,0), (1,3)
  task automatic test_directed();
    int rs[3] = '{0, 2, 1};
    int gs[3] = '{0, 0, 3};
    logic [3:0] act, want;
    for (int t = 0; t < 3; t++) begin
      build_expect(16'h0015, 5, rs[t], gs[t]);
      drive_start(16'h0015, 5, rs[t], gs[t]);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        start = 1'b0;
        act  = {d_valid, d_out, busy, done};
        want = full_exp(exp_q[i]);
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL directed t=%0d cyc=%0d got=%b want=%b", t, i + 1, act, want);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    logic [3:0] act, want;
    build_expect(16'hFFFF, 0, 0, 0);
    drive_start(16'hFFFF, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      act  = {d_valid, d_out, busy, done};
      want = full_exp(exp_q[i]);
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL len_zero cyc=%0d got=%b want=%b", i + 1, act, want);
      end
    end
  endtask

  // start held high and inputs scrambled through the frame, including the DONE cycle
  task automatic test_ignore_start();
    logic [3:0] act, want;
    int last;
    build_expect(16'h0015, 5, 1, 2);
    drive_start(16'h0015, 5, 1, 2);
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      start   = (i < last);
      pat_in  = MAX_W'($urandom);
      pat_len = LW'($urandom_range(1, MAX_W));
      rpt     = 8'($urandom);
      gap     = 4'($urandom);
      act  = {d_valid, d_out, busy, done};
      want = full_exp(exp_q[i]);
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL ignore_start cyc=%0d got=%b want=%b", i + 1, act, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] act, want;
    logic [2:0] seq;
    seq = 3'b101;
    drive_start(16'h0015, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      act  = {d_valid, d_out, busy, done};
      want = {1'b1, seq[2 - i], 1'b1, 1'b0};
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL reset_mid_bits cyc=%0d got=%b want=%b", i + 1, act, want);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      act  = {d_valid, d_out, busy, done};
      want = full_exp(4'b0000);
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL reset_mid_idle cyc=%0d got=%b want=%b", i, act, want);
      end
      @(negedge clk);
    end
    build_expect(16'h0015, 5, 0, 0);
    drive_start(16'h0015, 5, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      act  = {d_valid, d_out, busy, done};
      want = full_exp(exp_q[i]);
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL reset_mid_rerun cyc=%0d got=%b want=%b", i + 1, act, want);
      end
    end
  endtask

  // Random frames issued back to back: each start lands in the first IDLE cycle
  task automatic test_back_to_back();
    logic [3:0] act, want;
    logic [MAX_W-1:0] p;
    int len, r, g;
    for (int t = 0; t < 40; t++) begin
      p   = MAX_W'($urandom);
      len = $urandom_range(0, MAX_W + 3);
      r   = $urandom_range(0, 3);
      g   = $urandom_range(0, 4);
      build_expect(p, len, r, g);
      drive_start(p, len, r, g);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        start = 1'b0;
        act  = {d_valid, d_out, busy, done};
        want = full_exp(exp_q[i]);
        total++;
        if (act !== want) begin
          bad++;
          $display("FAIL random t=%0d len=%0d rpt=%0d gap=%0d cyc=%0d got=%b want=%b",
                   t, len, r, g, i + 1, act, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_len_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
